writeback_stage: RTL and testbench

- Final pipeline stage of the 16-bit RISC core, and the write side of the register file that Decode reads.
- Holds one retiring instruction in a MEM/WB register and selects the destination register (rt or rd) and the result (ALU or memory).
- Drives the register-file write port (RegWrite, write_reg, write_data), which Decode currently ties to 0.
- Also provides same-cycle forwarding to Decode's two read ports and counts retired instructions.

---
 rtl/writeback_if.sv | 44 ++++
 rtl/writeback_stage.sv | 68 ++++++
 tb/tb_writeback_stage.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/writeback_if.sv
// writeback_if: bundles the MEM->WB handshake, hazard controls, Decode read
// addresses, and the register-file write / forwarding outputs of the
// writeback stage.
//   master : MEM stage, hazard unit and Decode (drive inputs, observe results)
//   slave  : writeback_stage
interface writeback_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
);
  logic              in_valid;
  logic              in_ready;
  logic              reg_write_in;
  logic              mem_to_reg_in;
  logic              reg_dst_in;
  logic [REG_AW-1:0] rt_in;
  logic [REG_AW-1:0] rd_in;
  logic [DATA_W-1:0] alu_result_in;
  logic [DATA_W-1:0] mem_data_in;
  logic              hold;
  logic              flush;
  logic [REG_AW-1:0] src1_addr;
  logic [REG_AW-1:0] src2_addr;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              fwd_hit_1;
  logic              fwd_hit_2;
  logic [DATA_W-1:0] fwd_data;
  logic [15:0]       retired_count;

  modport master (
    output in_valid, reg_write_in, mem_to_reg_in, reg_dst_in, rt_in, rd_in,
           alu_result_in, mem_data_in, hold, flush, src1_addr, src2_addr,
    input  in_ready, rf_we, rf_waddr, rf_wdata, fwd_hit_1, fwd_hit_2,
           fwd_data, retired_count
  );

  modport slave (
    input  in_valid, reg_write_in, mem_to_reg_in, reg_dst_in, rt_in, rd_in,
           alu_result_in, mem_data_in, hold, flush, src1_addr, src2_addr,
    output in_ready, rf_we, rf_waddr, rf_wdata, fwd_hit_1, fwd_hit_2,
           fwd_data, retired_count
  );
endinterface

// File: rtl/writeback_stage.sv
// writeback_stage: final stage of the 16-bit RISC core. Holds one retiring
// instruction in the MEM/WB register, drives the register-file write port,
// forwards the value being written to Decode's two read ports in the same
// cycle, and counts committed instructions.
// Ports:
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : writeback_if.slave (handshake, hazard controls, RF write,
//              forwarding, retired_count)
module writeback_stage #(
  parameter int DATA_W      = 16,
  parameter int REG_AW      = 3,
  parameter bit ZERO_REG_RO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  writeback_if.slave  bus
);

  logic              wb_valid;
  logic              we_q;
  logic [REG_AW-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [15:0]       retired_q;

  logic commit;
  logic capture;
  logic zero_block;

  // Reset also gates commit so an entry caught by reset never writes.
  assign commit     = wb_valid && !bus.hold && !bus.flush && !rst;
  // Flush overrides hold, so the stage always drains the input under flush.
  assign bus.in_ready = !wb_valid || !bus.hold || bus.flush;
  assign capture    = bus.in_valid && bus.in_ready && !bus.flush;
  assign zero_block = ZERO_REG_RO && (waddr_q == '0);

  assign bus.rf_we         = commit && we_q && !zero_block;
  assign bus.rf_waddr      = waddr_q;
  assign bus.rf_wdata      = wdata_q;
  assign bus.fwd_hit_1     = bus.rf_we && (waddr_q == bus.src1_addr);
  assign bus.fwd_hit_2     = bus.rf_we && (waddr_q == bus.src2_addr);
  assign bus.fwd_data      = wdata_q;
  assign bus.retired_count = retired_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid  <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      retired_q <= '0;
    end else begin
      // Destination and result muxes are resolved here so later input
      // changes cannot disturb the latched entry.
      if (capture) begin
        we_q    <= bus.reg_write_in;
        waddr_q <= bus.reg_dst_in ? bus.rd_in : bus.rt_in;
        wdata_q <= bus.mem_to_reg_in ? bus.mem_data_in : bus.alu_result_in;
      end

      if (bus.flush)   wb_valid <= 1'b0;
      else if (capture) wb_valid <= 1'b1;
      else if (commit)  wb_valid <= 1'b0;

      if (commit) retired_q <= retired_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  writeback_if #(.DATA_W(16), .REG_AW(3)) bus ();

  writeback_stage #(.DATA_W(16), .REG_AW(3), .ZERO_REG_RO(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed and outputs
  // sampled 1ns after that edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic wr, input logic m2r, input logic dst,
                         input logic [2:0] rt, input logic [2:0] rd,
                         input logic [15:0] alu, input logic [15:0] mem);
    bus.in_valid      = 1'b1;
    bus.reg_write_in  = wr;
    bus.mem_to_reg_in = m2r;
    bus.reg_dst_in    = dst;
    bus.rt_in         = rt;
    bus.rd_in         = rd;
    bus.alu_result_in = alu;
    bus.mem_data_in   = mem;
  endtask

  initial begin
    int n;
    bus.hold = 1'b0;
    bus.flush = 1'b0;
    bus.src1_addr = 3'd0;
    bus.src2_addr = 3'd0;
    present(1'b1, 1'b0, 1'b1, 3'd1, 3'd1, 16'hDEAD, 16'h0000);

    // Reset held two cycles with a valid input presented
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("rst_we", 16'(bus.rf_we), 16'd0);
    chk("rst_cnt", bus.retired_count, 16'd0);
    chk("rst_ready", 16'(bus.in_ready), 16'd1);
    step();
    chk("rst_nocap_we", 16'(bus.rf_we), 16'd0);
    chk("rst_nocap_cnt", bus.retired_count, 16'd0);

    // ALU write to rd=3
    present(1'b1, 1'b0, 1'b1, 3'd6, 3'd3, 16'h1234, 16'h5555);
    step();
    bus.in_valid = 1'b0;
    bus.src1_addr = 3'd3;
    bus.src2_addr = 3'd6;
    #1;
    chk("alu_we", 16'(bus.rf_we), 16'd1);
    chk("alu_waddr", 16'(bus.rf_waddr), 16'd3);
    chk("alu_wdata", bus.rf_wdata, 16'h1234);
    chk("alu_hit1", 16'(bus.fwd_hit_1), 16'd1);
    chk("alu_hit2", 16'(bus.fwd_hit_2), 16'd0);
    chk("alu_fwd", bus.fwd_data, 16'h1234);
    step();
    chk("alu_cnt", bus.retired_count, 16'd1);
    chk("alu_idle_we", 16'(bus.rf_we), 16'd0);

    // Load to rt=5 back-to-back with ALU op to rd=2
    bus.src1_addr = 3'd7;
    bus.src2_addr = 3'd5;
    present(1'b1, 1'b1, 1'b0, 3'd5, 3'd7, 16'h1111, 16'hBEEF);
    step();
    present(1'b1, 1'b0, 1'b1, 3'd4, 3'd2, 16'h00A5, 16'h2222);
    #1;
    chk("ld_ready", 16'(bus.in_ready), 16'd1);
    chk("ld_we", 16'(bus.rf_we), 16'd1);
    chk("ld_waddr", 16'(bus.rf_waddr), 16'd5);
    chk("ld_wdata", bus.rf_wdata, 16'hBEEF);
    chk("ld_hit2", 16'(bus.fwd_hit_2), 16'd1);
    step();
    bus.in_valid = 1'b0;
    #1;
    chk("b2b_we", 16'(bus.rf_we), 16'd1);
    chk("b2b_waddr", 16'(bus.rf_waddr), 16'd2);
    chk("b2b_wdata", bus.rf_wdata, 16'h00A5);
    chk("b2b_hit2", 16'(bus.fwd_hit_2), 16'd0);
    step();
    chk("b2b_cnt", bus.retired_count, 16'd3);

    // Hold for three cycles with an entry for r4
    present(1'b1, 1'b0, 1'b1, 3'd0, 3'd4, 16'h4444, 16'h0000);
    step();
    bus.in_valid = 1'b0;
    bus.hold = 1'b1;
    bus.alu_result_in = 16'h9999;
    bus.rd_in = 3'd1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_we", 16'(bus.rf_we), 16'd0);
      chk("hold_ready", 16'(bus.in_ready), 16'd0);
      step();
    end
    bus.hold = 1'b0;
    #1;
    chk("hold_cnt_frozen", bus.retired_count, 16'd3);
    chk("hold_rel_we", 16'(bus.rf_we), 16'd1);
    chk("hold_rel_waddr", 16'(bus.rf_waddr), 16'd4);
    chk("hold_rel_wdata", bus.rf_wdata, 16'h4444);
    step();
    chk("hold_cnt", bus.retired_count, 16'd4);

    // Flush while occupied (with hold also asserted) and a new input presented
    present(1'b1, 1'b0, 1'b1, 3'd0, 3'd6, 16'h6666, 16'h0000);
    step();
    present(1'b1, 1'b0, 1'b1, 3'd0, 3'd1, 16'h7777, 16'h0000);
    bus.flush = 1'b1;
    bus.hold = 1'b1;
    #1;
    chk("flush_we", 16'(bus.rf_we), 16'd0);
    chk("flush_ready", 16'(bus.in_ready), 16'd1);
    step();
    bus.flush = 1'b0;
    bus.hold = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("flush_dropped_we", 16'(bus.rf_we), 16'd0);
    step();
    chk("flush_cnt", bus.retired_count, 16'd4);

    // Write to r0 is suppressed but still retires
    bus.src1_addr = 3'd0;
    bus.src2_addr = 3'd0;
    present(1'b1, 1'b0, 1'b1, 3'd3, 3'd0, 16'h0F0F, 16'h0000);
    step();
    bus.in_valid = 1'b0;
    #1;
    chk("r0_we", 16'(bus.rf_we), 16'd0);
    chk("r0_hit1", 16'(bus.fwd_hit_1), 16'd0);
    chk("r0_hit2", 16'(bus.fwd_hit_2), 16'd0);
    step();
    chk("r0_cnt", bus.retired_count, 16'd5);

    // Non-writing instruction (store) still retires
    present(1'b0, 1'b0, 1'b1, 3'd0, 3'd3, 16'h3333, 16'h0000);
    step();
    bus.in_valid = 1'b0;
    #1;
    chk("st_we", 16'(bus.rf_we), 16'd0);
    step();
    chk("st_cnt", bus.retired_count, 16'd6);

    // Stream non-writing instructions until the counter reaches FFFF
    present(1'b0, 1'b0, 1'b0, 3'd2, 3'd2, 16'h0000, 16'h0000);
    n = 0;
    while (bus.retired_count != 16'hFFFF && n < 70000) begin
      step();
      n++;
    end
    chk("wrap_reached", bus.retired_count, 16'hFFFF);
    bus.in_valid = 1'b0;
    step();
    chk("wrap_cnt", bus.retired_count, 16'h0000);

    // Reset while occupied: no write, entry discarded
    present(1'b1, 1'b0, 1'b1, 3'd0, 3'd1, 16'hAAAA, 16'h0000);
    step();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_occ_we", 16'(bus.rf_we), 16'd0);
    step();
    rst = 1'b0;
    #1;
    chk("rst_occ_after_we", 16'(bus.rf_we), 16'd0);
    chk("rst_occ_ready", 16'(bus.in_ready), 16'd1);
    step();
    chk("rst_occ_cnt", bus.retired_count, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
